imem_dmem_port_arbiter: RTL

- Shares one single-port synchronous program/data memory between two requesters: instruction fetch (driven from the PC) and data load/store (from the execute stage).
- Sequences every access through a small FSM, grants one requester at a time, and returns read data with a one-cycle valid pulse.
- Data accesses have priority; a starvation guard forces a fetch grant after a bounded run of data grants.
- A flush input discards an in-flight fetch when the PC is redirected by a taken branch or jump.

---
 rtl/imem_dmem_port_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and data load/store.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module imem_dmem_port_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] LP_LAT    = 3'(MEM_LAT);
    localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    state_t            r_state, w_state;
    logic              r_owner_dm, w_owner_dm;
    logic              r_drop, w_drop;
    logic [2:0]        r_cnt, w_cnt;
    logic [3:0]        r_starve, w_starve;
    logic              r_if_gnt, w_if_gnt;
    logic              r_dm_gnt, w_dm_gnt;
    logic              r_if_valid, w_if_valid;
    logic              r_dm_valid, w_dm_valid;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata;
    logic              r_mem_en, w_mem_en;
    logic              r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic              w_pick_if;
    logic              w_flush_hit;

    // Fetch wins only when data is absent or data has used up its run.
    assign w_pick_if   = if_req && (!dm_req || (r_starve == LP_STARVE));
    assign w_flush_hit = !r_owner_dm && if_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner_dm  <= 1'b0;
            r_drop      <= 1'b0;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state;
            r_owner_dm  <= w_owner_dm;
            r_drop      <= w_drop;
            r_cnt       <= w_cnt;
            r_starve    <= w_starve;
            r_if_gnt    <= w_if_gnt;
            r_dm_gnt    <= w_dm_gnt;
            r_if_valid  <= w_if_valid;
            r_dm_valid  <= w_dm_valid;
            r_if_rdata  <= w_if_rdata;
            r_dm_rdata  <= w_dm_rdata;
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_owner_dm  = r_owner_dm;
        w_drop      = r_drop;
        w_cnt       = r_cnt;
        w_starve    = r_starve;
        w_if_gnt    = 1'b0;
        w_dm_gnt    = 1'b0;
        w_if_valid  = 1'b0;
        w_dm_valid  = 1'b0;
        w_if_rdata  = r_if_rdata;
        w_dm_rdata  = r_dm_rdata;
        w_mem_en    = r_mem_en;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;

        case (r_state)
            IDLE: begin
                w_drop = 1'b0;
                if (if_req || dm_req) begin
                    w_mem_en = 1'b1;
                    w_state  = ACCESS;
                    if (w_pick_if) begin
                        w_owner_dm  = 1'b0;
                        w_mem_we    = 1'b0;
                        w_mem_addr  = if_addr;
                        w_mem_wdata = '0;
                        w_if_gnt    = 1'b1;
                        w_starve    = '0;
                    end else begin
                        w_owner_dm  = 1'b1;
                        w_mem_we    = dm_we;
                        w_mem_addr  = dm_addr;
                        w_mem_wdata = dm_wdata;
                        w_dm_gnt    = 1'b1;
                        // A data grant over a waiting fetch can only happen below the limit.
                        if (if_req) begin
                            w_starve = r_starve + 4'd1;
                        end
                    end
                end
            end
            ACCESS: begin
                w_mem_en = 1'b0;
                w_mem_we = 1'b0;
                if (w_flush_hit) begin
                    w_drop = 1'b1;
                end
                if (r_mem_we) begin
                    w_dm_valid = 1'b1;
                    w_state    = IDLE;
                end else begin
                    w_cnt   = 3'd1;
                    w_state = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == LP_LAT) begin
                    w_state = IDLE;
                    if (r_owner_dm) begin
                        w_dm_rdata = mem_rdata;
                        w_dm_valid = 1'b1;
                    end else if (!(r_drop || if_flush)) begin
                        w_if_rdata = mem_rdata;
                        w_if_valid = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 3'd1;
                    if (w_flush_hit) begin
                        w_drop = 1'b1;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign if_gnt    = r_if_gnt;
    assign dm_gnt    = r_dm_gnt;
    assign if_valid  = r_if_valid;
    assign dm_valid  = r_dm_valid;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

endmodule
